// File: rtl/debug_pkg.sv
// Shared types and constants for the GPR write-trace debug unit.
package debug_pkg;

  localparam int unsigned ARCH_WIDTH_DEF = 64;
  localparam int unsigned NUM_REGS_DEF   = 32;
  localparam int unsigned X0_IDX         = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } trace_state_e;

  typedef struct packed {
    logic [$clog2(NUM_REGS_DEF)-1:0] addr;
    logic [ARCH_WIDTH_DEF-1:0]       data;
  } trace_entry_t;

  // x0 is hardwired to zero, so writes to it carry no information.
  function automatic logic is_recordable(input logic en, input int unsigned idx);
    return en && (idx != X0_IDX);
  endfunction

endpackage

// File: rtl/debug_trace_buf.sv
// Flop-based circular trace buffer; a push into a full buffer drops the oldest entry.
module debug_trace_buf #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   wrapped
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full_c;

  assign full_c = (level == (PW+1)'(DEPTH));
  assign head_c = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  // Overwrite keeps level pinned at DEPTH and drags the read pointer along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      wrapped <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      wrapped <= 1'b0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PW'(1);
      if (full_c) begin
        rd_ptr  <= rd_ptr + PW'(1);
        wrapped <= 1'b1;
      end else begin
        level <= level + (PW+1)'(1);
      end
    end else if (pop && (level != '0)) begin
      rd_ptr <= rd_ptr + PW'(1);
      level  <= level - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/debug_gpr_trace.sv
// GPR write-port snooper: records committed writes, freezes on a masked trigger
// plus a post-trigger window, then streams the trace out oldest-first.
module debug_gpr_trace
  import debug_pkg::*;
#(
  parameter int unsigned ARCH_WIDTH = ARCH_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [ARCH_WIDTH-1:0]       wr_data,
  input  logic                        arm,
  input  logic                        abort,
  input  logic [$clog2(NUM_REGS)-1:0] trig_addr,
  input  logic [ARCH_WIDTH-1:0]       trig_value,
  input  logic [ARCH_WIDTH-1:0]       trig_mask,
  input  logic [$clog2(DEPTH)-1:0]    post_count,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [ARCH_WIDTH-1:0]       rd_data,
  output logic                        rd_last,
  output logic [1:0]                  state,
  output logic                        wrapped,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = AW + ARCH_WIDTH;

  trace_state_e  state_q, state_d;
  logic [PW-1:0] rem_q, rem_d;
  logic          rec_c, hit_c;
  logic          clr_c, push_c, pop_c;
  logic [EW-1:0] head_c;

  assign rec_c = is_recordable(wr_en, 32'(wr_addr));
  assign hit_c = rec_c && (wr_addr == trig_addr) &&
                 (((wr_data ^ trig_value) & trig_mask) == '0);

  debug_trace_buf #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr_c),
    .push    (push_c),
    .pop     (pop_c),
    .din     ({wr_addr, wr_data}),
    .head_c  (head_c),
    .level   (level),
    .wrapped (wrapped)
  );

  assign rd_valid = (state_q == ST_FROZEN) && (level != '0);
  assign rd_last  = rd_valid && (level == (PW+1)'(1));
  assign rd_addr  = head_c[EW-1:ARCH_WIDTH];
  assign rd_data  = head_c[ARCH_WIDTH-1:0];
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Abort wins over everything; hits after the trigger only count down the window.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    clr_c   = 1'b0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d = ST_ARMED;
            clr_c   = 1'b1;
          end
        end
        ST_ARMED: begin
          push_c = rec_c;
          if (hit_c) begin
            if (post_count == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
              rem_d   = post_count;
            end
          end
        end
        ST_POST: begin
          push_c = rec_c;
          if (rec_c) begin
            rem_d = rem_q - PW'(1);
            if (rem_q == PW'(1)) state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: begin
          pop_c = rd_valid && rd_ready;
          if (pop_c && rd_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/debug_gpr_trace.md
# debug_gpr_trace

Parametrised debug capture unit for the register file. It snoops the GPR write port and records each committed write (register index plus data) into a circular trace buffer. A programmable index/value/mask trigger then freezes the buffer a configurable number of writes later. Software or a debug bench drains the frozen trace oldest-first over a valid/ready stream.

## Interface
- ARCH_WIDTH, 64, GPR data width
- NUM_REGS, 32, architectural register count; index width AW = $clog2(NUM_REGS)
- DEPTH, 16, trace entries; power of two, ≥ 2; pointer width PW = $clog2(DEPTH)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  GPR write port strobe
- wr_addr  in  AW  GPR write index
- wr_data  in  ARCH_WIDTH  GPR write data
- arm  in  1  pulse; start a new capture
- abort  in  1  pulse; discard capture, return to IDLE
- trig_addr  in  AW  trigger register index
- trig_value  in  ARCH_WIDTH  trigger compare value
- trig_mask  in  ARCH_WIDTH  compare mask (1 = bit compared)
- post_count  in  PW  writes recorded after the trigger write
- rd_valid  out  1  trace entry available
- rd_ready  in  1  consumer accepts entry
- rd_addr  out  AW  entry register index
- rd_data  out  ARCH_WIDTH  entry data
- rd_last  out  1  entry is the final one
- state  out  2  IDLE=0, ARMED=1, POST=2, FROZEN=3
- wrapped  out  1  oldest entries were overwritten during this capture
- level  out  PW+1  entries currently held

## Operation
- Recordable write: wr_en && wr_addr != 0. Writes to x0 are never recorded and never trigger.
- Trigger hit: a recordable write with wr_addr == trig_addr and ((wr_data ^ trig_value) & trig_mask) == 0.
- IDLE: nothing is recorded. arm → ARMED; the same edge clears the pointers, level and wrapped.
- ARMED: every recordable write is appended. If level == DEPTH, the oldest entry is overwritten, the read pointer advances and wrapped is set. On a trigger hit the write is recorded, then:
  - post_count == 0 → FROZEN;
  - otherwise → POST, with remaining = post_count.
- POST: every recordable write is appended under the same overwrite rule and decrements remaining. The write that takes remaining to 0 → FROZEN. Trigger hits in POST are treated as ordinary writes.
- FROZEN: no recording. rd_valid = (level != 0). A transfer happens when rd_valid && rd_ready; it advances the read pointer and decrements level. The transfer with rd_last = 1 (level == 1) → IDLE.
  - FROZEN with level == 0 cannot occur, because the trigger write is always recorded.
- abort in any state → IDLE, level cleared. abort takes priority over arm and over a trigger hit in the same cycle.
- arm outside IDLE is ignored.
- Pointers wrap modulo DEPTH. level saturates at DEPTH.

## Timing
- Reset values: state = IDLE, rd_valid = 0, rd_last = 0, wrapped = 0, level = 0. rd_addr and rd_data = 0 because the buffer contents reset to 0.
- A recordable write at edge N is stored at edge N. level, wrapped and state reflect it in cycle N+1.
- Trigger detection is combinational on the write-port inputs. The freeze transition takes effect at the same edge as the write that completes the capture.
- rd_addr, rd_data and rd_last are combinational from the entry at the read pointer. They are valid in the first FROZEN cycle and are held stable while rd_valid && !rd_ready.
- Back-to-back transfers: one entry per cycle while rd_ready is held high.
- Reset asserted mid-capture or mid-drain: immediate return to reset values. No partial drain survives.

## Structure
- Package debug_pkg holds:
  - trace state enum (IDLE/ARMED/POST/FROZEN);
  - packed trace entry struct {addr, data}, parametrised by the ARCH_WIDTH and NUM_REGS widths;
  - the rule that x0 is index 0.
- Sub-module debug_trace_buf is the natural split: a flop-based circular buffer with push, push-overwrite, pop, level and wrapped. debug_gpr_trace keeps the FSM, trigger compare and post counter.

## Test plan
- Arm; write x5 = 0x11, x6 = 0x22, x7 = 0xDEAD with trig_addr = 7, trig_value = 0xDEAD, mask = all ones, post_count = 0 → FROZEN the next cycle, level = 3; drain yields (5,0x11), (6,0x22), (7,0xDEAD) with rd_last on the third; then state = IDLE.
- Arm, DEPTH = 16; 20 non-triggering writes x1 = 1..20, then trigger write → wrapped = 1, level = 16; drain starts at data 6 and ends with the trigger entry.
- post_count = 3: trigger on x10, then writes x11, x0, x12, x13 → the x0 write is not recorded; freeze occurs after the x13 write; level = 4.
- Mask = 0xFF, trig_value = 0x42: write x7 = 0x1234_5642 → triggers; write x7 = 0x43 → does not trigger.
- Hold rd_ready low for 5 cycles in FROZEN → rd_valid stays 1 and rd_data stays stable; then assert abort together with arm → IDLE, level = 0, arm ignored.
- Deassert rst_n during POST → state = IDLE, rd_valid = 0 and level = 0 asynchronously, before the next clock edge.
